// File: rtl/logicunit_arbiter.sv
// Round-robin scheduler sharing one external AND/OR/NOR/XOR unit among four
// requesters. A grant loads the unit's operand registers, the following edge
// captures its result, and the result is held on the response port until taken.
module logicunit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    output logic [3:0]         req_ready,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    input  logic [7:0]         req_op,
    output logic [WIDTH-1:0]   lu_a,
    output logic [WIDTH-1:0]   lu_b,
    output logic [1:0]         lu_control,
    input  logic [WIDTH-1:0]   lu_out,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [1:0]         resp_id,
    output logic [WIDTH-1:0]   resp_data,
    output logic [15:0]        ops_done
);
    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
    } req_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, cur_id, gnt_idx;
    logic       grant_win, gnt_found, hs, resp_hs;
    req_t       reqs [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign reqs[i] = '{a:  req_a[i*WIDTH +: WIDTH],
                           b:  req_b[i*WIDTH +: WIDTH],
                           op: req_op[2*i +: 2]};
    end

    // Pick the first valid requester after the last winner, wrapping around.
    always_comb begin
        logic [1:0] cand;
        cand      = ptr;
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grants open in IDLE, or in RESP when the pending result leaves this edge;
    // rst_n gating keeps req_ready low while reset is held.
    always_comb begin
        grant_win = (state == IDLE) || (state == RESP && resp_ready);
        req_ready = (rst_n && grant_win && gnt_found) ? (4'b0001 << gnt_idx) : 4'b0000;
        hs        = |(req_valid & req_ready);
        resp_hs   = resp_valid && resp_ready;
    end

    // Next-state logic; a grant always leads to EXEC, even out of RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = hs ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, rotation pointer and owner of the in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd3;
            cur_id <= 2'd0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                ptr    <= gnt_idx;
                cur_id <= gnt_idx;
            end
        end
    end

    // Operand registers for the shared unit; only a grant may change them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_a       <= '0;
            lu_b       <= '0;
            lu_control <= '0;
        end else if (hs) begin
            lu_a       <= reqs[gnt_idx].a;
            lu_b       <= reqs[gnt_idx].b;
            lu_control <= reqs[gnt_idx].op;
        end
    end

    // Capture the unit result after EXEC and hold it until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (state == EXEC) begin
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_data  <= lu_out;
        end else if (resp_hs) begin
            resp_valid <= 1'b0;
        end
    end

    // Completed response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ops_done <= '0;
        else if (resp_hs) ops_done <= ops_done + 16'd1;
    end
endmodule

// File: doc/logicunit_arbiter.md
# logicunit_arbiter

Round-robin scheduler that shares one combinational logic unit (AND/OR/NOR/XOR, 2-bit control) among four requesters. Each requester presents operands and an op code with a valid/ready handshake. The block grants one request at a time, drives the shared unit's A, B and control from registers, captures the result, and returns it with the requester's id over a valid/ready response port. It sits between client datapaths and the single logic-unit instance.

## Interface
- WIDTH, 32, operand/result width in bits
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_valid  in  4  per-requester request valid
- req_ready  out  4  per-requester accept; at most one bit high
- req_a  in  4*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  4*WIDTH  operand B, same packing
- req_op  in  8  op code; requester i at [2i+1:2i]; 0 AND, 1 OR, 2 NOR, 3 XOR
- lu_a  out  WIDTH  registered A to shared unit
- lu_b  out  WIDTH  registered B to shared unit
- lu_control  out  2  registered control to shared unit
- lu_out  in  WIDTH  shared unit result (combinational from lu_*)
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_id  out  2  index of requester that owns resp_data
- resp_data  out  WIDTH  captured result
- ops_done  out  16  count of completed response handshakes, wraps 65535 -> 0

## Operation
- States: IDLE, EXEC, RESP.
- Grant window is open in IDLE, and in RESP only when resp_ready=1 in the same cycle.
- In the grant window, the block picks the first valid requester, searching from (ptr+1) mod 4 upward with wrap. It drives req_ready for that requester only. req_ready is combinational from state, ptr, req_valid and resp_ready.
- Handshake is req_valid[g] & req_ready[g] at a rising edge. On handshake:
  - lu_a, lu_b and lu_control load requester g's operands and op.
  - cur_id is set to g and ptr is set to g.
  - State goes to EXEC.
- IDLE with no valid request: stay in IDLE. lu_* hold their last values.
- EXEC, at the next edge:
  - resp_data <= lu_out, resp_id <= cur_id, resp_valid <= 1.
  - State goes to RESP.
- RESP:
  - resp_valid, resp_data and resp_id stay stable until resp_valid & resp_ready.
  - On that handshake, ops_done increments.
  - If a new grant handshakes in the same edge, state goes to EXEC and resp_valid drops. Otherwise state goes to IDLE and resp_valid drops.
- lu_* change only on a request handshake; they are never altered in EXEC or RESP.
- req_ready is 0 in EXEC, in RESP while resp_ready=0, and whenever reset is low.
- A requester dropping req_valid before the handshake is legal and is simply not granted.
- No request is ever dropped or duplicated. Each handshake yields exactly one response.

## Timing
- Reset (async assert, synchronous release at the clock edge) sets:
  - state=IDLE, ptr=3 (requester 0 has first priority)
  - lu_a=0, lu_b=0, lu_control=0
  - resp_valid=0, resp_id=0, resp_data=0, ops_done=0, req_ready=0
- Latency: a request handshake at edge E0 gives resp_valid=1 after E1, i.e. two edges.
- Throughput with resp_ready held at 1: one grant every 2 cycles (RESP overlaps the next grant).
- Reset mid-EXEC or mid-RESP: the in-flight result is discarded, no response is issued, and ops_done returns to 0.
- Simultaneous resp handshake and new grant in RESP: both take effect at the same edge. ops_done increments, and the new result follows after the next edge.

## Test plan
- Reset: hold reset low with req_valid=4'hF and resp_ready=1. All outputs read 0 and req_ready=0. After release, the first grant goes to requester 0.
- Single op: requester 2 sends A=32'hF0F0F0F0, B=32'hFF00FF00, op=3. After two edges: resp_valid=1, resp_id=2, resp_data=32'h0FF00FF0. ops_done=1 after the resp handshake.
- Op encoding: requester 1 sends A=32'hC, B=32'hA with op=0,1,2,3. Results are 32'h8, 32'hE, 32'hFFFFFFF1, 32'h6.
- Round robin: req_valid=4'hF held and resp_ready=1 throughout. Grant order is 0,1,2,3,0,1 with a handshake every 2 cycles. resp_id follows the same order.
- Backpressure: resp_ready=0 for 5 cycles while in RESP.
  - resp_valid, resp_data and resp_id stay constant, and req_ready=0 throughout.
  - Raising resp_ready completes the response and grants the next requester in the same edge.
- Mid-op reset: pulse reset low during EXEC of requester 3. No response appears and ops_done=0. The next grant with req_valid=4'hF goes to requester 0.
